// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read/write paths: word geometry,
// transfer sizes and the writer state encoding.
package sram_pkg;

  localparam int ADDR_W         = 16;
  localparam int SAMPLE_W       = 16;
  localparam int WORD_W         = 2 * SAMPLE_W;

  // Transfer sizes shared with the read path.
  localparam int IMAGE_SAMPLES  = 64;
  localparam int WEIGHT_SAMPLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT_LO,
    ST_COLLECT_HI,
    ST_WRITE,
    ST_DONE
  } writer_state_e;

endpackage : sram_pkg

// File: rtl/sram_pack.sv
// Two-to-one sample packing register. The earlier sample lands in the low
// half; loading the low half also clears the high half, so an odd final
// sample produces a word whose upper half is zero.
module sram_pack #(
  parameter int SAMPLE_W = sram_pkg::SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic [SAMPLE_W-1:0]   sample,
  output logic [2*SAMPLE_W-1:0] word
);

  // Packing register: clear has priority, then low-half load, then high-half load.
  always_ff @(posedge clk) begin
    // NOTE: this is a plain data register, not a memory array, so it is
    // cleared on reset and the write_data output is a defined zero after reset.
    if (rst || clear) begin
      word <= '0;
    end else if (load_lo) begin
      word <= {{SAMPLE_W{1'b0}}, sample};
    end else if (load_hi) begin
      word[2*SAMPLE_W-1:SAMPLE_W] <= sample;
    end
  end

endmodule : sram_pack

// File: rtl/sram_writer.sv
// Stream-to-SRAM writer: packs pairs of 16-bit samples into 32-bit words and
// writes them at consecutive word addresses with a write/write_ack handshake.
// A one-cycle done pulse follows the last acknowledged write.
module sram_writer #(
  parameter int ADDR_W   = sram_pkg::ADDR_W,
  parameter int SAMPLE_W = sram_pkg::SAMPLE_W,
  parameter int CNT_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_address,
  input  logic [CNT_W-1:0]      n_samples,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [ADDR_W-1:0]     address,
  output logic [2*SAMPLE_W-1:0] write_data,
  output logic                  write,
  input  logic                  write_ack,
  output logic                  busy,
  output logic                  done
);

  import sram_pkg::*;

  writer_state_e     state_q;
  writer_state_e     state_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [ADDR_W-1:0] address_q;
  logic              load_lo;
  logic              load_hi;
  logic              clear_pack;

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of block order.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and packing-register controls.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    clear_pack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_pack = 1'b1;
          state_d    = (n_samples == '0) ? ST_DONE : ST_COLLECT_LO;
        end
      end
      ST_COLLECT_LO: begin
        if (sample_valid) begin
          load_lo = 1'b1;
          // Last sample of an odd count goes out with a zero upper half.
          state_d = (remaining_q == CNT_W'(1)) ? ST_WRITE : ST_COLLECT_HI;
        end
      end
      ST_COLLECT_HI: begin
        if (sample_valid) begin
          load_hi = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (write_ack) begin
          state_d = (remaining_q != '0) ? ST_COLLECT_LO : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Remaining-sample counter and word-address generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      address_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        remaining_q <= n_samples;
        address_q   <= start_address;
      end else if (load_lo || load_hi) begin
        remaining_q <= remaining_q - CNT_W'(1);
      end
      // Address advances on the acknowledging edge and wraps modulo 2^ADDR_W.
      if (state_q == ST_WRITE && write_ack) begin
        address_q <= address_q + ADDR_W'(1);
      end
    end
  end

  sram_pack #(
    .SAMPLE_W (SAMPLE_W)
  ) u_pack (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_pack),
    .load_lo (load_lo),
    .load_hi (load_hi),
    .sample  (sample_in),
    .word    (write_data)
  );

  // Outputs are decoded from state only.
  assign sample_ready = (state_q == ST_COLLECT_LO) || (state_q == ST_COLLECT_HI);
  assign write        = (state_q == ST_WRITE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign address      = address_q;

endmodule : sram_writer

// File: tb/tb_sram_writer.sv
// Directed bench for sram_writer. Expected SRAM words are pushed to a
// scoreboard queue as samples are driven and popped when the writer asks
// for a write. Inputs are driven and outputs sampled on the falling edge.
module tb_sram_writer;

  localparam int ADDR_W   = 16;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     start_address;
  logic [CNT_W-1:0]      n_samples;
  logic [SAMPLE_W-1:0]   sample_in;
  logic                  sample_valid;
  logic                  sample_ready;
  logic [ADDR_W-1:0]     address;
  logic [2*SAMPLE_W-1:0] write_data;
  logic                  write;
  logic                  write_ack;
  logic                  busy;
  logic                  done;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [2*SAMPLE_W-1:0] data;
  } wr_t;

  wr_t             sb_q[$];
  logic [15:0]     smp[$];
  int              n_checks = 0;
  int              n_errors = 0;

  sram_writer #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_address (start_address),
    .n_samples     (n_samples),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .address       (address),
    .write_data    (write_data),
    .write         (write),
    .write_ack     (write_ack),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_write"},        write,        1'b0);
    check({tag, "_busy"},         busy,         1'b0);
    check({tag, "_done"},         done,         1'b0);
    check({tag, "_sample_ready"}, sample_ready, 1'b0);
    check({tag, "_address"},      address,      '0);
    check({tag, "_write_data"},   write_data,   '0);
  endtask

  // Pulse start for one edge; afterwards the inputs carry junk to show they were latched.
  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    start         = 1'b1;
    start_address = a;
    n_samples     = n;
    @(negedge clk);
    start         = 1'b0;
    start_address = 16'hDEAD;
    n_samples     = 11'h3A5;
  endtask

  // Offer one sample after an optional stall with sample_valid low.
  task automatic send_sample(input logic [15:0] s, input int stall);
    int k = 0;
    while (!sample_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("sample_ready_wait", sample_ready, 1'b1);
    for (int i = 0; i < stall; i++) begin
      sample_valid = 1'b0;
      check("stall_ready", sample_ready, 1'b1);
      check("stall_no_write", write, 1'b0);
      @(negedge clk);
    end
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = 16'h0BAD;
  endtask

  // Serve one write request: hold for ack_delay cycles, then ack and compare.
  task automatic serve_write(input int ack_delay, input bit pulse_start);
    wr_t exp;
    int  k = 0;
    check("sb_nonempty", sb_q.size() != 0, 1'b1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    while (!write && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("write_rise", write, 1'b1);
    check("write_latency", k, 0);
    for (int i = 0; i < ack_delay; i++) begin
      check("hold_write", write, 1'b1);
      check("hold_address", address, exp.addr);
      check("hold_data", write_data, exp.data);
      check("hold_ready_low", sample_ready, 1'b0);
      check("hold_no_done", done, 1'b0);
      if (pulse_start) begin
        start         = 1'b1;
        start_address = 16'h5555;
        n_samples     = 11'd7;
      end
      @(negedge clk);
      start = 1'b0;
    end
    write_ack = 1'b1;
    check("wr_address", address, exp.addr);
    check("wr_data", write_data, exp.data);
    @(negedge clk);
    write_ack = 1'b0;
    check("write_fall", write, 1'b0);
  endtask

  // Complete transfer of the samples in smp[0..n-1].
  task automatic run_xfer(input logic [ADDR_W-1:0] a, input int n, input int ack_delay,
                          input int stall_hi, input bit pulse_start);
    logic [ADDR_W-1:0] addr = a;
    logic [15:0]       lo;
    logic [15:0]       hi;
    do_start(a, CNT_W'(n));
    if (n == 0) begin
      check("zero_done", done, 1'b1);
      check("zero_no_write", write, 1'b0);
      check("zero_busy", busy, 1'b1);
      @(negedge clk);
      check("zero_done_once", done, 1'b0);
      check("zero_idle", busy, 1'b0);
      return;
    end
    check("ready_after_start", sample_ready, 1'b1);
    for (int w = 0; w < (n + 1) / 2; w++) begin
      lo = smp[2*w];
      hi = (2*w + 1 < n) ? smp[2*w+1] : 16'h0000;
      sb_q.push_back({addr, hi, lo});
      send_sample(lo, 0);
      if (2*w + 1 < n) send_sample(hi, stall_hi);
      serve_write(ack_delay, pulse_start);
      addr = addr + 16'd1;
    end
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b1);
    check("end_address", address, addr);
    @(negedge clk);
    check("done_once", done, 1'b0);
    check("end_idle", busy, 1'b0);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    start_address = '0;
    n_samples     = '0;
    sample_in     = '0;
    sample_valid  = 1'b0;
    write_ack     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("por");
    rst = 1'b0;
    @(negedge clk);

    // Even transfer, ack in the same cycle write rises.
    smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_xfer(16'h0100, 4, 0, 0, 1'b0);

    // Odd transfer: last word has a zero upper half.
    smp = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_xfer(16'h0010, 3, 0, 0, 1'b0);

    // Delayed ack, stalled source in COLLECT_HI, start pulsed while busy.
    smp = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04, 16'h0E05};
    run_xfer(16'h0200, 5, 5, 3, 1'b1);

    // Zero count.
    run_xfer(16'h0300, 0, 0, 0, 1'b0);

    // Address wrap.
    smp = '{16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0};
    run_xfer(16'hFFFF, 4, 1, 0, 1'b0);

    // Reset mid-stream, held for two cycles.
    do_start(16'h0400, 11'd4);
    send_sample(16'h1234, 0);
    check("pre_reset_data", write_data, 32'h0000_1234);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_stream");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stream_stays_idle", busy, 1'b0);

    // Reset while write is asserted, then a fresh transfer.
    do_start(16'hFFFF, 11'd4);
    send_sample(16'h7777, 0);
    send_sample(16'h8888, 0);
    check("pre_reset_write", write, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_write");
    sb_q.delete();
    @(negedge clk);
    smp = '{16'hC0DE, 16'hBEEF};
    run_xfer(16'h0040, 2, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sram_writer
